dma_controller: RTL
===================

# dma_controller

Bus-master DMA engine for the shared MIPS/RAM bus. On a `start` pulse it requests the bus from the CPU via `HOLD`, waits for `HOLD_ACK`, then copies `length` 32-bit words from `src_addr` to `dst_addr`. Each word is one read followed by one write, using the IReady/TReady target handshake. When the block is finished it releases the bus. It sits beside the MIPS core and RAM as a second initiator on `Data_Bus`/`Address_Bus`/`Control`/`IReady`.

## Interface
- `ADDR_W`, 16, address width; matches `Address_Bus`.
- `DATA_W`, 32, data width; matches `Data_Bus`.
- `LEN_W`, 16, width of the word-count register.
- `clk`  in  1  single clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request pulse; sampled only in IDLE.
- `src_addr`  in  ADDR_W  first source word address; latched on accepted `start`.
- `dst_addr`  in  ADDR_W  first destination word address; latched on accepted `start`.
- `length`  in  LEN_W  number of words to copy; latched on accepted `start`.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  high together with `done` when the transfer was aborted; held until the next accepted `start`.
- `HOLD`  out  1  bus request to the CPU.
- `HOLD_ACK`  in  1  bus grant from the CPU.
- `Data_Bus`  inout  DATA_W  driven only in WR while granted, otherwise z.
- `Address_Bus`  inout  ADDR_W  driven only in RD/RD_END/WR/WR_END while granted, otherwise z.
- `Control`  inout  1  0 = read, 1 = write; driven under the same condition as `Address_Bus`.
- `IReady`  inout  1  initiator-ready strobe; driven under the same condition as `Address_Bus`.
- `TReady`  in  1  target acknowledge, sampled synchronously.

## Operation
- FSM states: IDLE, REQ, RD, RD_END, WR, WR_END, RELEASE.
- IDLE, `start` with `length` = 0:
  - pulse `done` the next cycle; `HOLD` is never raised.
- IDLE, `start` with `length` ≠ 0:
  - latch the addresses and count, set `busy`, go to REQ.
- REQ: `HOLD`=1; go to RD when `HOLD_ACK`=1.
- RD: drive `Address_Bus`=src, `Control`=0, `IReady`=1. When `TReady`=1, capture `Data_Bus` into the data register and go to RD_END.
- RD_END: `IReady`=0; wait for `TReady`=0, then go to WR.
- WR: drive `Address_Bus`=dst, `Data_Bus`=data, `Control`=1, `IReady`=1; go to WR_END on `TReady`=1.
- WR_END: `IReady`=0; wait for `TReady`=0. Then:
  - increment src and dst by 1 (modulo 2^ADDR_W, so addresses wrap);
  - decrement the count;
  - go to RELEASE if the count reaches 0, else go to RD.
- RELEASE: `HOLD`=0; on `HOLD_ACK`=0, pulse `done`, clear `busy`, go to IDLE.
- Loss of grant: if `HOLD_ACK` falls in RD, RD_END, WR or WR_END:
  - the bus drivers tristate combinationally in the same cycle;
  - the FSM goes to RELEASE with `err` set;
  - words already written stay written.
- `start` while `busy` is ignored.
- Reset (asserted at any time, including mid-transfer):
  - `HOLD`=0, `busy`=0, `done`=0, `err`=0;
  - all bus outputs z, state IDLE;
  - the address, count and data registers are cleared.

## Timing
- Each FSM state lasts at least 1 cycle; wait states hold until their condition is sampled at a posedge.
- Per-word minimum is 4 cycles (RD, RD_END, WR, WR_END) with a zero-wait target.
- Fixed overhead is ≥1 cycle in REQ plus ≥1 cycle in RELEASE.
- Minimum latency from `start` to `done`: 4·length + 3 cycles.
- All outputs are registered except the tristate enables, which are gated by `HOLD_ACK`.

## Configuration
- `DMA_CYCLE_STEAL_EN`
  - Defined: after every WR_END the block passes through a per-word release: `HOLD`=0, wait for `HOLD_ACK`=0, then re-enter REQ. The CPU gets at least one cycle of bus access between words.
  - Undefined (default): burst mode. `HOLD` stays high for the whole block.

## Structure
- Shared package `dma_pkg`: state encoding constants, `ADDR_W`/`DATA_W` defaults, and the `Control` read/write encodings (READ=0, WRITE=1), which are shared with the MIPS core and RAM.
- Sub-module `dma_bus_port`: tristate drivers plus the enable logic (grant AND drive-state). It is instantiated once.

## Test plan
- Burst copy, RAM[10..13]=`A0`,`A1`,`A2`,`A3`; start src=10, dst=40, length=4:
  - RAM[40..43] equals RAM[10..13];
  - `done` at cycle 19 with a zero-wait RAM;
  - `HOLD` high continuously.
- `length`=0:
  - `done` one cycle after `start`;
  - `HOLD` never asserts;
  - bus stays z.
- Delayed grant, CPU raises `HOLD_ACK` 5 cycles after `HOLD`:
  - no bus drive before the grant;
  - transfer of 1 word completes correctly.
- Grant withdrawn: drop `HOLD_ACK` in the WR state of word 2 of 3:
  - bus goes z in the same cycle;
  - `err`=1 and `done` pulse follow;
  - only word 1 is copied.
- Async reset mid-RD:
  - `HOLD`=0, `busy`=0, bus z immediately (no clock edge needed);
  - a new `start` afterwards completes normally.
- Wrap-around, src=`FFFE`, length=3:
  - reads from `FFFE`, `FFFF`, `0000`;
  - with `DMA_CYCLE_STEAL_EN`, `HOLD` additionally toggles low between words.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared DMA/bus definitions: FSM encoding, default widths and the Control
// read/write encodings common to the MIPS core, RAM and DMA.
package dma_pkg;
   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_LEN_W  = 16;

   localparam logic READ  = 1'b0;
   localparam logic WRITE = 1'b1;

   // STEAL is only entered when DMA_CYCLE_STEAL_EN is defined.
   typedef enum logic [2:0] {
      IDLE, REQ, RD, RD_END, WR, WR_END, RELEASE, STEAL
   } dma_state_t;

   function automatic logic drives_bus(input dma_state_t s);
      return (s == RD) || (s == RD_END) || (s == WR) || (s == WR_END);
   endfunction
endpackage

// File: rtl/dma_bus_port.sv
// Tristate drivers for the DMA side of the shared bus; every enable is
// qualified by the live HOLD_ACK so a withdrawn grant frees the bus at once.
module dma_bus_port #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              hold_ack,
   input  logic              drive_addr,
   input  logic              drive_data,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              ctrl,
   input  logic              iready,
   inout  wire  [DATA_W-1:0] Data_Bus,
   inout  wire  [ADDR_W-1:0] Address_Bus,
   inout  wire               Control,
   inout  wire               IReady
);
   logic en_addr;
   logic en_data;

   assign en_addr = hold_ack & drive_addr;
   assign en_data = hold_ack & drive_data;

   assign Address_Bus = en_addr ? addr   : 'z;
   assign Control     = en_addr ? ctrl   : 1'bz;
   assign IReady      = en_addr ? iready : 1'bz;
   assign Data_Bus    = en_data ? wdata  : 'z;
endmodule

// File: rtl/dma_controller.sv
// Bus-master DMA engine: copies `length` words src->dst over the shared bus.
// Define DMA_CYCLE_STEAL_EN to hand the bus back between words (default: burst).
module dma_controller
   import dma_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  length,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              HOLD,
   input  logic              HOLD_ACK,
   inout  wire  [DATA_W-1:0] Data_Bus,
   inout  wire  [ADDR_W-1:0] Address_Bus,
   inout  wire               Control,
   inout  wire               IReady,
   input  logic              TReady
);
   dma_state_t        state, state_d;
   logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              busy_d, done_d, err_d, abort_q, abort_d;
   logic              in_wr;

   always_comb begin
      state_d = state;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      busy_d  = busy;
      done_d  = 1'b0;
      err_d   = err;
      abort_d = abort_q;

      // Grant loss overrides every bus-phase transition.
      if (drives_bus(state) && !HOLD_ACK) begin
         abort_d = 1'b1;
         state_d = RELEASE;
      end else begin
         case (state)
            IDLE: if (start) begin
               err_d   = 1'b0;
               abort_d = 1'b0;
               if (length == '0) begin
                  done_d = 1'b1;
               end else begin
                  src_d   = src_addr;
                  dst_d   = dst_addr;
                  cnt_d   = length;
                  busy_d  = 1'b1;
                  state_d = REQ;
               end
            end
            REQ:    if (HOLD_ACK) state_d = RD;
            RD: if (TReady) begin
               data_d  = Data_Bus;
               state_d = RD_END;
            end
            RD_END: if (!TReady) state_d = WR;
            WR:     if (TReady) state_d = WR_END;
            WR_END: if (!TReady) begin
               src_d = src_q + ADDR_W'(1);
               dst_d = dst_q + ADDR_W'(1);
               cnt_d = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) begin
                  state_d = RELEASE;
               end else begin
`ifdef DMA_CYCLE_STEAL_EN
                  state_d = STEAL;
`else
                  state_d = RD;
`endif
               end
            end
            RELEASE: if (!HOLD_ACK) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               err_d   = abort_q;
               state_d = IDLE;
            end
            STEAL:   if (!HOLD_ACK) state_d = REQ;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         abort_q <= 1'b0;
         HOLD    <= 1'b0;
      end else begin
         state   <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         busy    <= busy_d;
         done    <= done_d;
         err     <= err_d;
         abort_q <= abort_d;
         HOLD    <= (state_d == REQ) || drives_bus(state_d);
      end
   end

   assign in_wr = (state == WR) || (state == WR_END);

   dma_bus_port #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_bus_port (
      .hold_ack   (HOLD_ACK),
      .drive_addr (drives_bus(state)),
      .drive_data (state == WR),
      .addr       (in_wr ? dst_q : src_q),
      .wdata      (data_q),
      .ctrl       (in_wr ? WRITE : READ),
      .iready     ((state == RD) || (state == WR)),
      .Data_Bus   (Data_Bus),
      .Address_Bus(Address_Bus),
      .Control    (Control),
      .IReady     (IReady)
   );
endmodule
